polaris_prefetch: RTL and testbench

//  Parametrised instruction prefetch queue between the Polaris I-master bus and
//  the sequencer's fetch stage. Fetches sequential 32-bit words ahead of

---
 rtl/polaris_prefetch_if.sv | 47 ++++
 rtl/polaris_prefetch.sv | 163 ++++++++++++++++
 tb/tb_polaris_prefetch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/polaris_prefetch_if.sv
// polaris_prefetch_if -- I-bus and fetch-stage signal bundle for polaris_prefetch.
//   master : the prefetch queue (drives iadr_o/isiz_o/istb_o, ivalid_o/iinst_o/ipc_o)
//   slave  : the environment (I-bus slave plus sequencer fetch stage)
// Signals:
//   iadr_o/isiz_o/istb_o, iack_i/idat_i     I-bus request / completion
//   redir_i/redir_pc_i                      flush and refetch from target
//   iready_i, ivalid_o/iinst_o/ipc_o        head-of-queue handshake
//   ierr_i, ifault_o, cause_o               only with POLARIS_PREFETCH_ERR_EN
// XLEN must match the XLEN of the polaris_prefetch instance it connects to.
interface polaris_prefetch_if #(
  parameter int unsigned XLEN = 64
);
  logic [XLEN-1:0] iadr_o;
  logic [1:0]      isiz_o;
  logic            istb_o;
  logic            iack_i;
  logic [31:0]     idat_i;
  logic            redir_i;
  logic [XLEN-1:0] redir_pc_i;
  logic            iready_i;
  logic            ivalid_o;
  logic [31:0]     iinst_o;
  logic [XLEN-1:0] ipc_o;
`ifdef POLARIS_PREFETCH_ERR_EN
  logic            ierr_i;
  logic            ifault_o;
  logic [3:0]      cause_o;
`endif

  modport master (
    output iadr_o, isiz_o, istb_o, ivalid_o, iinst_o, ipc_o,
`ifdef POLARIS_PREFETCH_ERR_EN
    output ifault_o, cause_o,
    input  ierr_i,
`endif
    input  iack_i, idat_i, redir_i, redir_pc_i, iready_i
  );

  modport slave (
    input  iadr_o, isiz_o, istb_o, ivalid_o, iinst_o, ipc_o,
`ifdef POLARIS_PREFETCH_ERR_EN
    input  ifault_o, cause_o,
    output ierr_i,
`endif
    output iack_i, idat_i, redir_i, redir_pc_i, iready_i
  );
endinterface

// File: rtl/polaris_prefetch.sv
// polaris_prefetch -- instruction prefetch queue between the Polaris I-master
// bus and the sequencer fetch stage. Sequential 32-bit words are fetched ahead
// of execution into a DEPTH-entry FIFO of {pc, inst} pairs; a redirect flushes
// the queue and restarts fetch at the (word-aligned) target.
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   reset_ni  synchronous active-low reset; all outputs forced to 0 while low
//   bus       polaris_prefetch_if.master (I-bus request side + fetch handshake)
// Optional feature macro: POLARIS_PREFETCH_ERR_EN
//   adds ierr_i / ifault_o / cause_o; FIFO carries a fault flag. A bus error
//   queues a fault entry (cause 1) and stalls fetch until redirect; a redirect
//   to a misaligned target queues a fault entry (cause 0) without a bus cycle.
//   Without it, redir_pc_i[1:0] is ignored and bus errors are unsupported.
module polaris_prefetch #(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  polaris_prefetch_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {
    FETCH,
    DISCARD
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] adr_q;
  logic            open_q;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [31:0]     mem_inst [DEPTH];

  logic            stb;
  logic            hold;
  logic            push;
  logic            pop;
  logic            valid;
  logic [XLEN-1:0] cur_adr;
  logic            bus_err;
  logic            stopped;
  logic            misaligned;

`ifdef POLARIS_PREFETCH_ERR_EN
  logic mem_fault [DEPTH];
  logic mem_cause [DEPTH];

  assign bus_err    = bus.ierr_i;
  assign misaligned = |bus.redir_pc_i[1:0];
`else
  logic unused_redir_lsb;

  assign bus_err          = 1'b0;
  assign stopped          = 1'b0;
  assign misaligned       = 1'b0;
  assign unused_redir_lsb = ^bus.redir_pc_i[1:0];
`endif

  // An open cycle keeps its captured address; this is also what DISCARD
  // presents while fpc already holds the redirect target.
  assign cur_adr = open_q ? adr_q : fpc;
  assign stb     = reset_ni & (open_q | ((state == FETCH) && (count < CW'(DEPTH)) && !stopped));
  // Bus has seen the request but not completed it: must not be aborted.
  assign hold    = stb & ~bus.iack_i;
  assign push    = stb & bus.iack_i & (state == FETCH) & ~bus.redir_i;
  assign valid   = reset_ni & (count != '0);
  assign pop     = valid & bus.iready_i & ~bus.redir_i;

  assign bus.istb_o   = stb;
  assign bus.iadr_o   = stb ? cur_adr : '0;
  assign bus.isiz_o   = stb ? 2'b10 : 2'b00;
  assign bus.ivalid_o = valid;
  assign bus.iinst_o  = valid ? mem_inst[rd_ptr] : '0;
  assign bus.ipc_o    = valid ? mem_pc[rd_ptr] : '0;
`ifdef POLARIS_PREFETCH_ERR_EN
  assign bus.ifault_o = valid & mem_fault[rd_ptr];
  assign bus.cause_o  = {3'b000, valid & mem_fault[rd_ptr] & mem_cause[rd_ptr]};
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state  <= FETCH;
      fpc    <= RESET_VEC;
      adr_q  <= '0;
      open_q <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
`ifdef POLARIS_PREFETCH_ERR_EN
      stopped <= 1'b0;
`endif
    end else begin
      open_q <= hold;
      if (hold) begin
        adr_q <= cur_adr;
      end
      if (bus.redir_i) begin
        // A redirect that lands on an acked cycle simply drops its data;
        // one that lands on a still-open cycle must wait it out in DISCARD.
        state  <= hold ? DISCARD : FETCH;
        fpc    <= {bus.redir_pc_i[XLEN-1:2], 2'b00};
        rd_ptr <= '0;
`ifdef POLARIS_PREFETCH_ERR_EN
        stopped <= misaligned;
`endif
        if (misaligned) begin
          count  <= CW'(1);
          wr_ptr <= AW'(1);
        end else begin
          count  <= '0;
          wr_ptr <= '0;
        end
      end else begin
        if ((state == DISCARD) && bus.iack_i) begin
          state <= FETCH;
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (!bus_err) begin
            fpc <= fpc + XLEN'(4);
          end
`ifdef POLARIS_PREFETCH_ERR_EN
          if (bus_err) begin
            stopped <= 1'b1;
          end
`endif
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_ni) begin
      if (bus.redir_i && misaligned) begin
        mem_pc[0]   <= bus.redir_pc_i;
        mem_inst[0] <= '0;
`ifdef POLARIS_PREFETCH_ERR_EN
        mem_fault[0] <= 1'b1;
        mem_cause[0] <= 1'b0;
`endif
      end else if (push) begin
        mem_pc[wr_ptr]   <= fpc;
        mem_inst[wr_ptr] <= bus_err ? '0 : bus.idat_i;
`ifdef POLARIS_PREFETCH_ERR_EN
        mem_fault[wr_ptr] <= bus_err;
        mem_cause[wr_ptr] <= bus_err;
`endif
      end
    end
  end
endmodule

// File: tb/tb_polaris_prefetch.sv
// tb_polaris_prefetch -- self-checking bench for polaris_prefetch
// (XLEN=64, DEPTH=4, RESET_VEC=64'hFFFF_FFFF_FFFF_FF00).
module tb_polaris_prefetch;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RV    = 64'hFFFF_FFFF_FFFF_FF00;
  localparam logic [63:0] TOP   = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  polaris_prefetch_if #(.XLEN(XLEN)) bus ();

  polaris_prefetch #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_VEC(RV)
  ) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  int total  = 0;
  int bad    = 0;
  int cyc_no = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc_no, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ack, input logic [31:0] dat,
                       input logic rd, input logic [63:0] rpc, input logic rdy);
    rst_n          = r;
    bus.iack_i     = ack;
    bus.idat_i     = dat;
    bus.redir_i    = rd;
    bus.redir_pc_i = rpc;
    bus.iready_i   = rdy;
`ifdef POLARIS_PREFETCH_ERR_EN
    bus.ierr_i     = 1'b0;
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic        ack;
    logic [31:0] dat;
    logic        rd;
    logic [63:0] rpc;
    logic        rdy;
    logic        stb;
    logic [63:0] adr;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t tv [17];

  // ---------------- reference model ----------------
  // Queue of fetched words in program order, the next fetch address, and the
  // address of a request the bus has seen but not yet completed.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq [$];
  logic [63:0] m_fpc     = RV;
  logic [63:0] m_out_adr = '0;
  bit          m_out     = 1'b0;
  bit          m_disc    = 1'b0;

  task automatic mstep(input logic r, input logic ack, input logic [31:0] dat,
                       input logic rd, input logic [63:0] rpc, input logic rdy);
    bit          e_stb;
    bit          e_valid;
    logic [63:0] e_adr;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    e_stb   = r && (m_out || (mq.size() < DEPTH));
    e_adr   = e_stb ? (m_out ? m_out_adr : m_fpc) : 64'h0;
    e_valid = r && (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc : 64'h0;
    e_inst  = e_valid ? mq[0].inst : 32'h0;
    drive(r, ack, dat, rd, rpc, rdy);
    #1;
    check("m_stb",   {63'h0, bus.istb_o},   {63'h0, e_stb});
    check("m_adr",   bus.iadr_o,            e_adr);
    check("m_siz",   {62'h0, bus.isiz_o},   e_stb ? 64'h2 : 64'h0);
    check("m_valid", {63'h0, bus.ivalid_o}, {63'h0, e_valid});
    check("m_pc",    bus.ipc_o,             e_pc);
    check("m_inst",  {32'h0, bus.iinst_o},  {32'h0, e_inst});
    if (!r) begin
      mq.delete();
      m_fpc  = RV;
      m_out  = 1'b0;
      m_disc = 1'b0;
    end else if (rd) begin
      mq.delete();
      m_fpc = {rpc[63:2], 2'b00};
      if (e_stb && !ack) begin
        m_out     = 1'b1;
        m_disc    = 1'b1;
        m_out_adr = e_adr;
      end else begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
    end else begin
      if (e_valid && rdy) void'(mq.pop_front());
      if (e_stb && ack) begin
        if (!m_disc) begin
          mq.push_back('{pc: m_fpc, inst: dat});
          m_fpc = m_fpc + 64'd4;
        end
        m_out  = 1'b0;
        m_disc = 1'b0;
      end else if (e_stb) begin
        m_out     = 1'b1;
        m_out_adr = e_adr;
      end
    end
    #3;
    cyc();
  endtask

  initial begin
    //        r     ack   dat           rd    rpc            rdy   stb   adr           valid pc            inst
    tv[0]  = '{1'b0, 1'b1, 32'h0,        1'b0, 64'h0,         1'b0, 1'b0, 64'h0,        1'b0, 64'h0,        32'h0};
    tv[1]  = '{1'b1, 1'b1, 32'hA000_0001, 1'b0, 64'h0,        1'b0, 1'b1, RV,           1'b0, 64'h0,        32'h0};
    tv[2]  = '{1'b1, 1'b1, 32'hA000_0002, 1'b0, 64'h0,        1'b0, 1'b1, RV + 64'd4,   1'b1, RV,           32'hA000_0001};
    tv[3]  = '{1'b1, 1'b1, 32'hA000_0003, 1'b0, 64'h0,        1'b0, 1'b1, RV + 64'd8,   1'b1, RV,           32'hA000_0001};
    tv[4]  = '{1'b1, 1'b1, 32'hA000_0004, 1'b0, 64'h0,        1'b0, 1'b1, RV + 64'd12,  1'b1, RV,           32'hA000_0001};
    tv[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 64'h0,         1'b0, 1'b0, 64'h0,        1'b1, RV,           32'hA000_0001};
    tv[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 64'h0,         1'b1, 1'b0, 64'h0,        1'b1, RV,           32'hA000_0001};
    tv[7]  = '{1'b1, 1'b1, 32'hA000_0006, 1'b0, 64'h0,        1'b1, 1'b1, RV + 64'd16,  1'b1, RV + 64'd4,   32'hA000_0002};
    tv[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 64'h1000,      1'b1, 1'b1, RV + 64'd20,  1'b1, RV + 64'd8,   32'hA000_0003};
    tv[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 64'h0,         1'b0, 1'b1, RV + 64'd20,  1'b0, 64'h0,        32'h0};
    tv[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 64'h0,         1'b0, 1'b1, RV + 64'd20,  1'b0, 64'h0,        32'h0};
    tv[11] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0,        1'b0, 1'b1, RV + 64'd20,  1'b0, 64'h0,        32'h0};
    tv[12] = '{1'b1, 1'b1, 32'hB000_0001, 1'b0, 64'h0,        1'b0, 1'b1, 64'h1000,     1'b0, 64'h0,        32'h0};
    tv[13] = '{1'b1, 1'b0, 32'h0,        1'b0, 64'h0,         1'b0, 1'b1, 64'h1004,     1'b1, 64'h1000,     32'hB000_0001};
    tv[14] = '{1'b1, 1'b1, 32'hB000_0002, 1'b1, TOP,          1'b1, 1'b1, 64'h1004,     1'b1, 64'h1000,     32'hB000_0001};
    tv[15] = '{1'b1, 1'b1, 32'hC000_0001, 1'b0, 64'h0,        1'b0, 1'b1, TOP,          1'b0, 64'h0,        32'h0};
    tv[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 64'h0,         1'b0, 1'b1, 64'h0,        1'b1, TOP,          32'hC000_0001};

    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    #1;
    for (int i = 0; i < 17; i++) begin
      drive(tv[i].r, tv[i].ack, tv[i].dat, tv[i].rd, tv[i].rpc, tv[i].rdy);
      #1;
      check("tv_stb",   {63'h0, bus.istb_o},   {63'h0, tv[i].stb});
      check("tv_adr",   bus.iadr_o,            tv[i].adr);
      check("tv_siz",   {62'h0, bus.isiz_o},   tv[i].stb ? 64'h2 : 64'h0);
      check("tv_valid", {63'h0, bus.ivalid_o}, {63'h0, tv[i].valid});
      check("tv_pc",    bus.ipc_o,             tv[i].pc);
      check("tv_inst",  {32'h0, bus.iinst_o},  {32'h0, tv[i].inst});
      cyc();
    end

    // Double redirect while a stale cycle is still open.
    mstep(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    mstep(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    mstep(1'b1, 1'b0, 32'h0, 1'b1, 64'h2000, 1'b0);
    mstep(1'b1, 1'b0, 32'h0, 1'b1, 64'h3001, 1'b0);
    mstep(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 64'h0, 1'b0);
    mstep(1'b1, 1'b1, 32'h1234_5678, 1'b0, 64'h0, 1'b1);
    #1;
    check("dbl_redir_pc", bus.ipc_o, 64'h3000);
    #3;

    // Randomized traffic against the reference model.
    mstep(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    for (int n = 0; n < 4000; n++) begin
      logic        r;
      logic        ack;
      logic        rd;
      logic        rdy;
      logic [63:0] rpc;
      r   = ($urandom_range(0, 299) != 0);
      ack = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rpc[63:6] = '1;
`ifdef POLARIS_PREFETCH_ERR_EN
      rpc[1:0] = 2'b00;
`endif
      mstep(r, ack, $urandom, rd, rpc, rdy);
    end

`ifdef POLARIS_PREFETCH_ERR_EN
    // Bus error on the second fetch, then a misaligned redirect.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    cyc();
    drive(1'b1, 1'b1, 32'hE000_0001, 1'b0, 64'h0, 1'b0);
    #1;
    check("err_first_adr", bus.iadr_o, RV);
    cyc();
    drive(1'b1, 1'b1, 32'hE000_0002, 1'b0, 64'h0, 1'b0);
    bus.ierr_i = 1'b1;
    #1;
    check("err_second_adr", bus.iadr_o, RV + 64'd4);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    #1;
    check("err_stall_stb", {63'h0, bus.istb_o}, 64'h0);
    check("err_head_fault", {63'h0, bus.ifault_o}, 64'h0);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    #1;
    check("err_head_pc", bus.ipc_o, RV);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 64'h1002, 1'b0);
    #1;
    check("err_entry_pc", bus.ipc_o, RV + 64'd4);
    check("err_entry_fault", {63'h0, bus.ifault_o}, 64'h1);
    check("err_entry_cause", {60'h0, bus.cause_o}, 64'h1);
    check("err_entry_stb", {63'h0, bus.istb_o}, 64'h0);
    cyc();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    #1;
    check("mis_valid", {63'h0, bus.ivalid_o}, 64'h1);
    check("mis_pc", bus.ipc_o, 64'h1002);
    check("mis_fault", {63'h0, bus.ifault_o}, 64'h1);
    check("mis_cause", {60'h0, bus.cause_o}, 64'h0);
    check("mis_stb", {63'h0, bus.istb_o}, 64'h0);
    cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
